branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

In-order queue that carries each predicted branch from fetch to execute in the dual-issue pipeline. It captures the PC, predicted direction and predicted target of up to two branches per cycle at fetch. It matches them against the two execute-stage outcomes. It then drives the branch history table update signals (branch/taken/PC per lane) and a single registered mispredict redirect with a full flush.

## Interface
- DEPTH, 8: entries; power of two, ≥4.
- PC_W, 11: PC width; word-addressed.
- clk  in  1  clock.
- reset  in  1  async, active-low.
- enq_valid1, enq_valid2  in  1 each  fetch lane 1/2 holds a branch; lane 1 is older.
- enq_pc1, enq_pc2  in  PC_W each  branch PC.
- enq_pred1, enq_pred2  in  1 each  predicted taken.
- enq_tgt1, enq_tgt2  in  PC_W each  predicted target.
- enq_ready  out  1  ≥2 free entries.
- res_valid1, res_valid2  in  1 each  execute resolved oldest / second-oldest entry.
- res_taken1, res_taken2  in  1 each  actual direction.
- res_tgt1, res_tgt2  in  PC_W each  actual target.
- upd_branch1, upd_branch2  out  1 each  BHT update strobe.
- upd_taken1, upd_taken2  out  1 each  actual direction.
- upd_pc1, upd_pc2  out  PC_W each  PC of the resolved branch.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  PC_W  correct next PC.
- count  out  clog2(DEPTH)+1  occupied entries.
- err_underflow  out  1  sticky; resolve arrived with no matching entry.

## Operation
- Enqueue occurs only when enq_ready=1. With enq_ready=0, enq_valid is ignored and fetch must stall.
- Lanes are compacted: only valid2 writes one entry at tail. Both valid writes lane 1 at tail and lane 2 at tail+1.
- Resolve applies to head (lane 1) and head+1 (lane 2). res_valid2 without res_valid1 is ignored.
- Mispredict per lane: pred≠taken, or pred=taken=1 with predicted target≠actual target.
- Correct PC: taken ? res_tgt : pc+1, where pc+1 wraps mod 2^PC_W.
- Lane 1 mispredicts:
  - lane 2 result is discarded, so upd_branch2=0;
  - all entries are flushed (head=tail, count=0);
  - redirect_pc = lane 1 correct PC.
- Lane 2 only mispredicts: both lanes update, all entries are flushed, and redirect_pc = lane 2 correct PC.
- No mispredict: the resolved entries pop (1 or 2).
- Same-cycle enqueue and flush: the flush wins and the enqueue is dropped.
- Enqueue concurrent with a pop (no flush) is allowed. count = count + enq − pop.
- Resolve on a lane with no entry (count=0, or count=1 for lane 2):
  - that lane is ignored, with no update and no mispredict;
  - err_underflow is set;
  - only reset clears err_underflow.
- Pointers wrap mod DEPTH.

## Timing
- Reset values: all upd_*=0, mispredict=0, redirect_pc=0, count=0, err_underflow=0, enq_ready=1, pointers=0.
- An entry enqueued in cycle N is resolvable in cycle N+1.
- upd_*, mispredict and redirect_pc are registered and assert in cycle R+1 after resolve cycle R, for exactly one cycle.
- count and enq_ready are combinational from the registered pointers. The flush is visible at R+1 (enq_ready=1).
- Reset mid-operation: the queue empties immediately and any pending update or redirect is cancelled.

## Configuration
- BRQ_STATS_EN defined: adds 32-bit saturating outputs stat_resolved and stat_mispred.
  - stat_resolved increments by the number of updated lanes.
  - stat_mispred increments by 1 per mispredict.
  - Both are reset to 0.
- Not defined: these ports and the counters are absent, and all other behaviour is identical.

## Structure
- Shared package brq_pkg holds:
  - the entry struct {pc, pred, tgt};
  - the PC_W default;
  - the function mispredict_check(pred, tgt_pred, taken, tgt_act) returning {miss, correct_pc}.
- One sub-module, brq_lane_check: purely combinational, instantiated twice, wrapping mispredict_check.
- Storage, pointers and output registers stay in the top.

## Test plan
- Reset, then enqueue pc1=5 pred=1 tgt=20 and pc2=9 pred=0; resolve both correct -> next cycle upd_branch1=upd_branch2=1, upd_pc1=5, upd_pc2=9, mispredict=0, count=0.
- Enqueue pc=7 pred=0; resolve taken tgt=30 -> mispredict=1, redirect_pc=30, upd_taken1=1, count=0.
- Two entries: lane 1 pc=3 pred=1 tgt=12, resolved not taken -> redirect_pc=4, upd_branch2=0, queue flushed.
- Fill to DEPTH-1 -> enq_ready=0 and a further enqueue is ignored. Pop one -> enq_ready=1. Verify pointer wrap over 3×DEPTH pushes.
- Enqueue pc=2047 pred=1 tgt=0, resolve not taken -> redirect_pc=0 (wrap).
- Resolve with empty queue -> no upd, err_underflow=1 held until reset. Flush concurrent with enqueue -> count=0.

Source files
------------

// File: rtl/brq_pkg.sv
// Shared types and the per-lane mispredict check for the branch resolve queue.
package brq_pkg;

    localparam int BRQ_PC_W  = 11;
    localparam int BRQ_DEPTH = 8;

    typedef struct packed {
        logic [BRQ_PC_W-1:0] pc;
        logic                pred;
        logic [BRQ_PC_W-1:0] tgt;
    } brq_entry_t;

    typedef struct packed {
        logic                miss;
        logic [BRQ_PC_W-1:0] correct_pc;
    } brq_check_t;

    // The branch PC is needed for the fall-through address of a not-taken branch.
    function automatic brq_check_t mispredict_check(
        input logic [BRQ_PC_W-1:0] pc,
        input logic                pred,
        input logic [BRQ_PC_W-1:0] tgt_pred,
        input logic                taken,
        input logic [BRQ_PC_W-1:0] tgt_act
    );
        brq_check_t r;
        r.miss       = (pred != taken) || (pred && taken && (tgt_pred != tgt_act));
        r.correct_pc = taken ? tgt_act : pc + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/brq_lane_check.sv
// Combinational outcome check for one resolve lane against its queue entry.
module brq_lane_check
    import brq_pkg::*;
(
    input  brq_entry_t          entry,
    input  logic                taken,
    input  logic [BRQ_PC_W-1:0] tgt,
    output logic                miss,
    output logic [BRQ_PC_W-1:0] correct_pc
);

    brq_check_t result;

    assign result     = mispredict_check(entry.pc, entry.pred, entry.tgt, taken, tgt);
    assign miss       = result.miss;
    assign correct_pc = result.correct_pc;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order predicted-branch queue from fetch to execute with BHT update and redirect.
// Optional build macro BRQ_STATS_EN adds saturating stat_resolved / stat_mispred counters.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int PC_W  = BRQ_PC_W
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid1,
    input  logic                      enq_valid2,
    input  logic [PC_W-1:0]           enq_pc1,
    input  logic [PC_W-1:0]           enq_pc2,
    input  logic                      enq_pred1,
    input  logic                      enq_pred2,
    input  logic [PC_W-1:0]           enq_tgt1,
    input  logic [PC_W-1:0]           enq_tgt2,
    output logic                      enq_ready,
    input  logic                      res_valid1,
    input  logic                      res_valid2,
    input  logic                      res_taken1,
    input  logic                      res_taken2,
    input  logic [PC_W-1:0]           res_tgt1,
    input  logic [PC_W-1:0]           res_tgt2,
    output logic                      upd_branch1,
    output logic                      upd_branch2,
    output logic                      upd_taken1,
    output logic                      upd_taken2,
    output logic [PC_W-1:0]           upd_pc1,
    output logic [PC_W-1:0]           upd_pc2,
    output logic                      mispredict,
    output logic [PC_W-1:0]           redirect_pc,
    output logic [$clog2(DEPTH):0]    count,
`ifdef BRQ_STATS_EN
    output logic [31:0]               stat_resolved,
    output logic [31:0]               stat_mispred,
`endif
    output logic                      err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    brq_entry_t     mem [DEPTH];
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]    head;
    logic [AW:0]    tail;
    logic [AW-1:0]  head_idx;
    logic [AW-1:0]  head_idx1;
    logic [AW-1:0]  tail_idx;
    logic [AW-1:0]  tail_idx1;

    brq_entry_t     ent1;
    brq_entry_t     ent2;
    brq_entry_t     in1;
    brq_entry_t     in2;

    logic           chk_miss1;
    logic           chk_miss2;
    logic [PC_W-1:0] cpc1;
    logic [PC_W-1:0] cpc2;

    logic           avail1;
    logic           avail2;
    logic           req1;
    logic           req2;
    logic           upd1;
    logic           upd2;
    logic           miss1;
    logic           miss2;
    logic           flush;
    logic           under;
    logic           do_enq;
    logic [AW:0]    n_enq;
    logic [AW:0]    n_pop;

    assign count     = tail - head;
    assign enq_ready = (count <= READY_MAX);

    assign head_idx  = head[AW-1:0];
    assign head_idx1 = head[AW-1:0] + AW'(1);
    assign tail_idx  = tail[AW-1:0];
    assign tail_idx1 = tail[AW-1:0] + AW'(1);

    assign ent1 = mem[head_idx];
    assign ent2 = mem[head_idx1];
    assign in1  = '{pc: enq_pc1, pred: enq_pred1, tgt: enq_tgt1};
    assign in2  = '{pc: enq_pc2, pred: enq_pred2, tgt: enq_tgt2};

    brq_lane_check u_check1 (
        .entry      (ent1),
        .taken      (res_taken1),
        .tgt        (res_tgt1),
        .miss       (chk_miss1),
        .correct_pc (cpc1)
    );

    brq_lane_check u_check2 (
        .entry      (ent2),
        .taken      (res_taken2),
        .tgt        (res_tgt2),
        .miss       (chk_miss2),
        .correct_pc (cpc2)
    );

    // Lane 2 only counts alongside lane 1; a lane without an entry is dropped and flagged.
    always_comb begin
        avail1 = (count != '0);
        avail2 = (count >= (AW+1)'(2));
        req1   = res_valid1;
        req2   = res_valid1 & res_valid2;
        upd1   = req1 & avail1;
        miss1  = upd1 & chk_miss1;
        upd2   = req2 & avail2 & ~miss1;
        miss2  = upd2 & chk_miss2;
        flush  = miss1 | miss2;
        under  = (req1 & ~avail1) | (req2 & ~avail2);
        do_enq = enq_ready & ~flush & (enq_valid1 | enq_valid2);
        n_enq  = (AW+1)'(enq_valid1) + (AW+1)'(enq_valid2);
        n_pop  = (AW+1)'(upd1) + (AW+1)'(upd2);
    end

    // Lane 2 lands at tail when lane 1 is empty, keeping entries compact.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            if (enq_valid1) mem[tail_idx] <= in1;
            if (enq_valid2) mem[enq_valid1 ? tail_idx1 : tail_idx] <= in2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            upd_branch1   <= 1'b0;
            upd_branch2   <= 1'b0;
            upd_taken1    <= 1'b0;
            upd_taken2    <= 1'b0;
            upd_pc1       <= '0;
            upd_pc2       <= '0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (flush) begin
                head <= tail;
            end else begin
                head <= head + n_pop;
                if (do_enq) tail <= tail + n_enq;
            end
            upd_branch1   <= upd1;
            upd_branch2   <= upd2;
            upd_taken1    <= upd1 & res_taken1;
            upd_taken2    <= upd2 & res_taken2;
            upd_pc1       <= upd1 ? ent1.pc : '0;
            upd_pc2       <= upd2 ? ent2.pc : '0;
            mispredict    <= flush;
            redirect_pc   <= miss1 ? cpc1 : (miss2 ? cpc2 : '0);
            err_underflow <= err_underflow | under;
        end
    end

`ifdef BRQ_STATS_EN
    logic [32:0] res_sum;

    assign res_sum = {1'b0, stat_resolved} + 33'(upd1) + 33'(upd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            stat_resolved <= res_sum[32] ? '1 : res_sum[31:0];
            if (flush && (stat_mispred != '1)) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed table-driven bench for branch_resolve_queue (DEPTH=8, PC_W=11).
module tb_branch_resolve_queue;

    logic        clk;
    logic        reset;
    logic        enq_valid1, enq_valid2;
    logic [10:0] enq_pc1, enq_pc2;
    logic        enq_pred1, enq_pred2;
    logic [10:0] enq_tgt1, enq_tgt2;
    logic        enq_ready;
    logic        res_valid1, res_valid2;
    logic        res_taken1, res_taken2;
    logic [10:0] res_tgt1, res_tgt2;
    logic        upd_branch1, upd_branch2;
    logic        upd_taken1, upd_taken2;
    logic [10:0] upd_pc1, upd_pc2;
    logic        mispredict;
    logic [10:0] redirect_pc;
    logic [3:0]  count;
    logic        err_underflow;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif

    branch_resolve_queue #(.DEPTH(8), .PC_W(11)) dut (
        .clk           (clk),
        .reset         (reset),
        .enq_valid1    (enq_valid1),
        .enq_valid2    (enq_valid2),
        .enq_pc1       (enq_pc1),
        .enq_pc2       (enq_pc2),
        .enq_pred1     (enq_pred1),
        .enq_pred2     (enq_pred2),
        .enq_tgt1      (enq_tgt1),
        .enq_tgt2      (enq_tgt2),
        .enq_ready     (enq_ready),
        .res_valid1    (res_valid1),
        .res_valid2    (res_valid2),
        .res_taken1    (res_taken1),
        .res_taken2    (res_taken2),
        .res_tgt1      (res_tgt1),
        .res_tgt2      (res_tgt2),
        .upd_branch1   (upd_branch1),
        .upd_branch2   (upd_branch2),
        .upd_taken1    (upd_taken1),
        .upd_taken2    (upd_taken2),
        .upd_pc1       (upd_pc1),
        .upd_pc2       (upd_pc2),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .count         (count),
`ifdef BRQ_STATS_EN
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred),
`endif
        .err_underflow (err_underflow)
    );

    typedef struct {
        logic        v1;
        logic [10:0] pc1;
        logic        p1;
        logic [10:0] t1;
        logic        v2;
        logic [10:0] pc2;
        logic        p2;
        logic [10:0] t2;
    } enq_t;

    typedef struct {
        logic        v1;
        logic        k1;
        logic [10:0] g1;
        logic        v2;
        logic        k2;
        logic [10:0] g2;
    } res_t;

    typedef struct {
        logic        b1;
        logic        k1;
        logic [10:0] u1;
        logic        b2;
        logic        k2;
        logic [10:0] u2;
        logic        mis;
        logic [10:0] rpc;
        logic [3:0]  cnt;
        logic        rdy;
        logic        err;
    } exp_t;

    typedef struct {
        enq_t e;
        res_t r;
        exp_t x;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    logic [10:0] exp_q[$];

    function automatic enq_t mk_e(int v1, int pc1, int p1, int t1, int v2, int pc2, int p2, int t2);
        enq_t e;
        e.v1 = 1'(v1); e.pc1 = 11'(pc1); e.p1 = 1'(p1); e.t1 = 11'(t1);
        e.v2 = 1'(v2); e.pc2 = 11'(pc2); e.p2 = 1'(p2); e.t2 = 11'(t2);
        return e;
    endfunction

    function automatic res_t mk_r(int v1, int k1, int g1, int v2, int k2, int g2);
        res_t r;
        r.v1 = 1'(v1); r.k1 = 1'(k1); r.g1 = 11'(g1);
        r.v2 = 1'(v2); r.k2 = 1'(k2); r.g2 = 11'(g2);
        return r;
    endfunction

    function automatic exp_t mk_x(int b1, int k1, int u1, int b2, int k2, int u2,
                                  int mis, int rpc, int cnt, int rdy, int err);
        exp_t x;
        x.b1 = 1'(b1); x.k1 = 1'(k1); x.u1 = 11'(u1);
        x.b2 = 1'(b2); x.k2 = 1'(k2); x.u2 = 11'(u2);
        x.mis = 1'(mis); x.rpc = 11'(rpc); x.cnt = 4'(cnt); x.rdy = 1'(rdy); x.err = 1'(err);
        return x;
    endfunction

    function automatic vec_t mk_v(enq_t e, res_t r, exp_t x);
        vec_t v;
        v.e = e; v.r = r; v.x = x;
        return v;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        enq_valid1 = 0; enq_valid2 = 0;
        enq_pc1 = '0; enq_pc2 = '0; enq_pred1 = 0; enq_pred2 = 0; enq_tgt1 = '0; enq_tgt2 = '0;
        res_valid1 = 0; res_valid2 = 0; res_taken1 = 0; res_taken2 = 0; res_tgt1 = '0; res_tgt2 = '0;
    endtask

    task automatic drive(input enq_t e, input res_t r);
        enq_valid1 = e.v1; enq_pc1 = e.pc1; enq_pred1 = e.p1; enq_tgt1 = e.t1;
        enq_valid2 = e.v2; enq_pc2 = e.pc2; enq_pred2 = e.p2; enq_tgt2 = e.t2;
        res_valid1 = r.v1; res_taken1 = r.k1; res_tgt1 = r.g1;
        res_valid2 = r.v2; res_taken2 = r.k2; res_tgt2 = r.g2;
    endtask

    task automatic check_out(input string tag, input exp_t x);
        chk({tag, " upd_branch1"}, 32'(upd_branch1), 32'(x.b1));
        chk({tag, " upd_taken1"},  32'(upd_taken1),  32'(x.k1));
        chk({tag, " upd_pc1"},     32'(upd_pc1),     32'(x.u1));
        chk({tag, " upd_branch2"}, 32'(upd_branch2), 32'(x.b2));
        chk({tag, " upd_taken2"},  32'(upd_taken2),  32'(x.k2));
        chk({tag, " upd_pc2"},     32'(upd_pc2),     32'(x.u2));
        chk({tag, " mispredict"},  32'(mispredict),  32'(x.mis));
        chk({tag, " redirect_pc"}, 32'(redirect_pc), 32'(x.rpc));
        chk({tag, " count"},       32'(count),       32'(x.cnt));
        chk({tag, " enq_ready"},   32'(enq_ready),   32'(x.rdy));
        chk({tag, " err_underflow"}, 32'(err_underflow), 32'(x.err));
    endtask

    // One clock per vector: drive at negedge, compare 1 time unit after the posedge.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        drive(v.e, v.r);
        @(posedge clk);
        #1;
        check_out(tag, v.x);
        drive_idle();
    endtask

    vec_t tbl [19];
    enq_t e0;
    res_t r0;
    exp_t xa;

    initial begin
        e0 = mk_e(0, 0, 0, 0, 0, 0, 0, 0);
        r0 = mk_r(0, 0, 0, 0, 0, 0);

        tbl[0]  = mk_v(mk_e(1, 5, 1, 20, 1, 9, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 2,1,0));
        tbl[1]  = mk_v(e0, mk_r(1, 1, 20, 1, 0, 0),    mk_x(1,1,5, 1,0,9, 0,0, 0,1,0));
        tbl[2]  = mk_v(mk_e(1, 7, 0, 0, 0, 0, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 1,1,0));
        tbl[3]  = mk_v(e0, mk_r(1, 1, 30, 0, 0, 0),    mk_x(1,1,7, 0,0,0, 1,30, 0,1,0));
        tbl[4]  = mk_v(mk_e(1, 3, 1, 12, 1, 4, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 2,1,0));
        tbl[5]  = mk_v(e0, mk_r(1, 0, 0, 1, 0, 0),     mk_x(1,0,3, 0,0,0, 1,4, 0,1,0));
        tbl[6]  = mk_v(mk_e(0, 0, 0, 0, 1, 2047, 1, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 1,1,0));
        tbl[7]  = mk_v(e0, mk_r(1, 0, 0, 0, 0, 0),     mk_x(1,0,2047, 0,0,0, 1,0, 0,1,0));
        tbl[8]  = mk_v(mk_e(1, 10, 0, 0, 1, 11, 1, 40), r0, mk_x(0,0,0, 0,0,0, 0,0, 2,1,0));
        tbl[9]  = mk_v(e0, mk_r(1, 0, 0, 1, 1, 41),    mk_x(1,0,10, 1,1,11, 1,41, 0,1,0));
        tbl[10] = mk_v(mk_e(1, 20, 0, 0, 0, 0, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 1,1,0));
        tbl[11] = mk_v(mk_e(1, 21, 0, 0, 1, 22, 0, 0), mk_r(1, 0, 0, 0, 0, 0),
                       mk_x(1,0,20, 0,0,0, 0,0, 2,1,0));
        tbl[12] = mk_v(e0, mk_r(1, 0, 0, 1, 0, 0),     mk_x(1,0,21, 1,0,22, 0,0, 0,1,0));
        tbl[13] = mk_v(e0, mk_r(0, 0, 0, 1, 1, 5),     mk_x(0,0,0, 0,0,0, 0,0, 0,1,0));
        tbl[14] = mk_v(mk_e(1, 30, 1, 50, 0, 0, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 1,1,0));
        tbl[15] = mk_v(mk_e(1, 31, 0, 0, 1, 32, 0, 0), mk_r(1, 1, 51, 0, 0, 0),
                       mk_x(1,1,30, 0,0,0, 1,51, 0,1,0));
        tbl[16] = mk_v(e0, r0,                         mk_x(0,0,0, 0,0,0, 0,0, 0,1,0));
        tbl[17] = mk_v(e0, mk_r(1, 0, 0, 0, 0, 0),     mk_x(0,0,0, 0,0,0, 0,0, 0,1,1));
        tbl[18] = mk_v(e0, r0,                         mk_x(0,0,0, 0,0,0, 0,0, 0,1,1));

        drive_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", mk_x(0,0,0, 0,0,0, 0,0, 0,1,0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Fill to DEPTH-1, confirm the blocked enqueue is dropped, then drain in order.
        apply("fill1", mk_v(mk_e(1, 200, 0, 0, 1, 201, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 2,1,1)));
        apply("fill2", mk_v(mk_e(1, 202, 0, 0, 1, 203, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 4,1,1)));
        apply("fill3", mk_v(mk_e(1, 204, 0, 0, 1, 205, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 6,1,1)));
        apply("fill4", mk_v(mk_e(1, 206, 0, 0, 0, 0, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 7,0,1)));
        apply("full",  mk_v(mk_e(1, 207, 1, 99, 1, 208, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 7,0,1)));
        apply("pop1",  mk_v(e0, mk_r(1, 0, 0, 0, 0, 0), mk_x(1,0,200, 0,0,0, 0,0, 6,1,1)));
        apply("drain1", mk_v(e0, mk_r(1, 0, 0, 1, 0, 0), mk_x(1,0,201, 1,0,202, 0,0, 4,1,1)));
        apply("drain2", mk_v(e0, mk_r(1, 0, 0, 1, 0, 0), mk_x(1,0,203, 1,0,204, 0,0, 2,1,1)));
        apply("drain3", mk_v(e0, mk_r(1, 0, 0, 1, 0, 0), mk_x(1,0,205, 1,0,206, 0,0, 0,1,1)));

        // 3*DEPTH pushes so both pointers wrap several times.
        for (int i = 0; i < 12; i++) begin
            int pc;
            logic [10:0] a, b;
            pc = 500 + 2 * i;
            exp_q.push_back(11'(pc));
            exp_q.push_back(11'(pc + 1));
            apply($sformatf("wrap_enq%0d", i),
                  mk_v(mk_e(1, pc, 0, 0, 1, pc + 1, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 2,1,1)));
            a = exp_q.pop_front();
            b = exp_q.pop_front();
            apply($sformatf("wrap_res%0d", i),
                  mk_v(e0, mk_r(1, 0, 0, 1, 0, 0), mk_x(1,0,int'(a), 1,0,int'(b), 0,0, 0,1,1)));
        end

        // Reset during a mispredicting resolve cancels the redirect and clears the sticky error.
        apply("pre_rst", mk_v(mk_e(1, 300, 1, 60, 0, 0, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 1,1,1)));
        @(negedge clk);
        drive(e0, mk_r(1, 0, 0, 0, 0, 0));
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_out("mid_rst", mk_x(0,0,0, 0,0,0, 0,0, 0,1,0));
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        apply("post_rst_enq", mk_v(mk_e(1, 400, 0, 0, 0, 0, 0, 0), r0, mk_x(0,0,0, 0,0,0, 0,0, 1,1,0)));
        apply("post_rst_res", mk_v(e0, mk_r(1, 0, 0, 0, 0, 0), mk_x(1,0,400, 0,0,0, 0,0, 0,1,0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
